// File: rtl/branch_predict_if.sv
// Fetch/execute bundle between the pipeline and the branch predictor.
// Optional statistics signals are present only when BRANCH_STATS_EN is defined.
interface branch_predict_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] if_pc;
  logic              pred_taken;
  logic              ex_valid;
  logic              ex_is_branch;
  logic [ADDR_W-1:0] ex_pc;
  logic              ex_pred_taken;
  logic              branch_estab;
  logic [ADDR_W-1:0] ex_target;
  logic              mispredict;
  logic [ADDR_W-1:0] redirect_pc;
`ifdef BRANCH_STATS_EN
  logic [31:0]       stat_branches;
  logic [31:0]       stat_mispredicts;
`endif

  // Pipeline side: supplies PCs and resolved outcomes
  modport master (
    output if_pc, ex_valid, ex_is_branch, ex_pc, ex_pred_taken, branch_estab, ex_target,
`ifdef BRANCH_STATS_EN
    input  stat_branches, stat_mispredicts,
`endif
    input  pred_taken, mispredict, redirect_pc
  );

  // Predictor side
  modport slave (
    input  if_pc, ex_valid, ex_is_branch, ex_pc, ex_pred_taken, branch_estab, ex_target,
`ifdef BRANCH_STATS_EN
    output stat_branches, stat_mispredicts,
`endif
    output pred_taken, mispredict, redirect_pc
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Untagged PC-indexed table of 2-bit saturating counters: predicts at IF,
// trains and resolves mispredictions at EX.
// Optional feature macro: BRANCH_STATS_EN (branch / mispredict counters).
module branch_predict_unit #(
  parameter int unsigned BHT_IDX_W = 6,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_predict_if.slave      bus
);

  localparam int unsigned BHT_ENTRIES = 1 << BHT_IDX_W;
  localparam int unsigned CTR_W       = 2;
  localparam int unsigned STAT_W      = 32;
  localparam logic [CTR_W-1:0] CTR_RESET = 2'b01;

  logic [CTR_W-1:0]     bht_q [BHT_ENTRIES];
  logic [BHT_IDX_W-1:0] if_idx;
  logic [BHT_IDX_W-1:0] ex_idx;
  logic [CTR_W-1:0]     ex_ctr;
  logic [CTR_W-1:0]     ex_ctr_next;
  logic                 upd;
  logic                 mispredict_c;

  assign if_idx = bus.if_pc[BHT_IDX_W+1:2];
  assign ex_idx = bus.ex_pc[BHT_IDX_W+1:2];
  assign upd    = bus.ex_valid & bus.ex_is_branch;
  assign ex_ctr = bht_q[ex_idx];

  // Saturating increment/decrement of the entry being trained
  always_comb begin
    ex_ctr_next = ex_ctr;
    if (bus.branch_estab) begin
      if (ex_ctr != 2'b11) ex_ctr_next = ex_ctr + CTR_W'(1);
    end else begin
      if (ex_ctr != 2'b00) ex_ctr_next = ex_ctr - CTR_W'(1);
    end
  end

  // Counter table: all entries weakly-not-taken on reset, one write per update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CTR_RESET;
    end else if (upd) begin
      bht_q[ex_idx] <= ex_ctr_next;
    end
  end

  // Lookup with same-index bypass so IF sees the counter being written this cycle
  always_comb begin
    bus.pred_taken = bht_q[if_idx][1];
    if (rst_n && upd && (if_idx == ex_idx)) bus.pred_taken = ex_ctr_next[1];
  end

  // Resolve: flush and redirect when the piped prediction disagrees with the outcome
  always_comb begin
    mispredict_c    = rst_n & upd & (bus.ex_pred_taken != bus.branch_estab);
    bus.mispredict  = mispredict_c;
    bus.redirect_pc = '0;
    if (mispredict_c) begin
      bus.redirect_pc = bus.branch_estab ? bus.ex_target : (bus.ex_pc + ADDR_W'(4));
    end
  end

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] stat_branches_q;
  logic [STAT_W-1:0] stat_mispredicts_q;

  // Saturating event counters for resolved branches and mispredictions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      if (upd && (stat_branches_q != '1))
        stat_branches_q <= stat_branches_q + STAT_W'(1);
      if (mispredict_c && (stat_mispredicts_q != '1))
        stat_mispredicts_q <= stat_mispredicts_q + STAT_W'(1);
    end
  end

  assign bus.stat_branches    = stat_branches_q;
  assign bus.stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit with an expected-value scoreboard.
module tb_branch_predict_unit;

  localparam int unsigned ADDR_W = 32;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  logic [31:0] exp_q[$];
  logic [1:0]  ref_ctr [64];

  branch_predict_if #(.ADDR_W(ADDR_W)) bif ();

  branch_predict_unit #(.BHT_IDX_W(6), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL %s scoreboard empty, observed=0x%08h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, e);
      end
    end
  endtask

  task automatic drive_ex(input logic v, input logic br, input logic [31:0] pc,
                          input logic pt, input logic est, input logic [31:0] tgt);
    bif.ex_valid      = v;
    bif.ex_is_branch  = br;
    bif.ex_pc         = pc;
    bif.ex_pred_taken = pt;
    bif.branch_estab  = est;
    bif.ex_target     = tgt;
  endtask

  task automatic model_train(input logic [31:0] pc, input logic est);
    int i;
    i = int'(pc[7:2]);
    if (est && ref_ctr[i] != 2'b11) ref_ctr[i] = ref_ctr[i] + 2'd1;
    if (!est && ref_ctr[i] != 2'b00) ref_ctr[i] = ref_ctr[i] - 2'd1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) ref_ctr[i] = 2'b01;
  endtask

  logic [2:0] seq_est;
  logic [4:0] train_out;
  logic [4:0] train_exp;
  logic [9:0] stat_mis;

  initial begin
    tests = 0;
    fails = 0;
    model_reset();
    rst_n = 1'b0;
    bif.if_pc = 32'h0;
    drive_ex(1'b1, 1'b1, 32'h104, 1'b1, 1'b0, 32'h0);

    // Outputs held quiet while in reset even with a mismatching branch presented
    #12;
    push_exp(32'h0); check("rst_mispredict", 32'(bif.mispredict));
    push_exp(32'h0); check("rst_redirect", bif.redirect_pc);
    push_exp(32'h0); check("rst_pred", 32'(bif.pred_taken));
    drive_ex(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sweep every index: all weakly-not-taken after reset
    for (int a = 0; a < 64; a++) begin
      bif.if_pc = 32'(a * 4);
      #1;
      push_exp(32'(ref_ctr[a][1]));
      check("sweep_pred", 32'(bif.pred_taken));
    end
    push_exp(32'h0); check("sweep_mispredict", 32'(bif.mispredict));

    // Train 0x100: T,T,N,N,N; read stored prediction after each edge
    train_out = 5'b00011;
    train_exp = 5'b00111;
    bif.if_pc = 32'h100;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive_ex(1'b1, 1'b1, 32'h100, ref_ctr[0][1], train_out[k], 32'h400);
      model_train(32'h100, train_out[k]);
      @(posedge clk);
      #1;
      drive_ex(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      #1;
      push_exp(32'(train_exp[k])); check("train_pred", 32'(bif.pred_taken));
    end

    // Predicted not-taken, actually taken -> redirect to target
    @(negedge clk);
    drive_ex(1'b1, 1'b1, 32'h100, 1'b0, 1'b1, 32'h240);
    model_train(32'h100, 1'b1);
    #1;
    push_exp(32'h1);   check("mp_taken_flag", 32'(bif.mispredict));
    push_exp(32'h240); check("mp_taken_pc", bif.redirect_pc);

    // Predicted taken, actually not taken -> fall through
    @(negedge clk);
    drive_ex(1'b1, 1'b1, 32'h104, 1'b1, 1'b0, 32'h500);
    model_train(32'h104, 1'b0);
    #1;
    push_exp(32'h1);   check("mp_ntaken_flag", 32'(bif.mispredict));
    push_exp(32'h108); check("mp_ntaken_pc", bif.redirect_pc);

    // Fall-through wraps at the top of the address space
    @(negedge clk);
    drive_ex(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h600);
    model_train(32'hFFFF_FFFC, 1'b0);
    #1;
    push_exp(32'h1); check("mp_wrap_flag", 32'(bif.mispredict));
    push_exp(32'h0); check("mp_wrap_pc", bif.redirect_pc);

    // Correct prediction -> no redirect
    @(negedge clk);
    drive_ex(1'b1, 1'b1, 32'h108, 1'b0, 1'b0, 32'h700);
    model_train(32'h108, 1'b0);
    #1;
    push_exp(32'h0); check("ok_flag", 32'(bif.mispredict));
    push_exp(32'h0); check("ok_pc", bif.redirect_pc);

    // Bypass: 0x100 counter is 01; taken resolve on the same index shows 1 immediately
    @(negedge clk);
    drive_ex(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    bif.if_pc = 32'h100;
    #1;
    push_exp(32'(ref_ctr[0][1])); check("bypass_before", 32'(bif.pred_taken));
    drive_ex(1'b1, 1'b1, 32'h100, 1'b0, 1'b1, 32'h240);
    model_train(32'h100, 1'b1);
    #1;
    push_exp(32'h1); check("bypass_same_cycle", 32'(bif.pred_taken));

    // One more taken to saturate, then read through an alias
    @(negedge clk);
    drive_ex(1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 32'h240);
    model_train(32'h100, 1'b1);
    @(negedge clk);
    drive_ex(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    bif.if_pc = 32'h200;
    #1;
    push_exp(32'h1); check("alias_pred", 32'(bif.pred_taken));

    // Gated updates: non-branch and invalid slot must neither flush nor train
    drive_ex(1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 32'h0);
    #1;
    push_exp(32'h0); check("gate_nb_flag", 32'(bif.mispredict));
    push_exp(32'h0); check("gate_nb_pc", bif.redirect_pc);
    @(negedge clk);
    drive_ex(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0);
    #1;
    push_exp(32'h0); check("gate_inv_flag", 32'(bif.mispredict));
    @(negedge clk);
    drive_ex(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    push_exp(32'(ref_ctr[0][1])); check("gate_table_kept", 32'(bif.pred_taken));

    // Reset mid-run discards history immediately
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    push_exp(32'(ref_ctr[0][1])); check("midrst_pred", 32'(bif.pred_taken));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    push_exp(32'h0); check("postrst_pred", 32'(bif.pred_taken));

`ifdef BRANCH_STATS_EN
    // Ten resolved branches, three of them mispredicted
    stat_mis = 10'b0100100100;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive_ex(1'b1, 1'b1, 32'h300, 1'b0, stat_mis[k], 32'h340);
    end
    @(negedge clk);
    drive_ex(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    push_exp(32'd10); check("stat_branches", bif.stat_branches);
    push_exp(32'd3);  check("stat_mispredicts", bif.stat_mispredicts);

    // Counters saturate instead of wrapping
    dut.stat_branches_q    = 32'hFFFF_FFFD;
    dut.stat_mispredicts_q = 32'hFFFF_FFFE;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive_ex(1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 32'h340);
    end
    @(negedge clk);
    drive_ex(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    push_exp(32'hFFFF_FFFF); check("stat_br_sat", bif.stat_branches);
    push_exp(32'hFFFF_FFFF); check("stat_mp_sat", bif.stat_mispredicts);
`endif

    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
